regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 12 +
 rtl/regfile_scoreboard_if.sv | 28 ++
 rtl/regfile_scoreboard_reg_reserve_table.sv | 47 ++++
 rtl/regfile_scoreboard.sv | 60 ++++++
 tb/tb_regfile_scoreboard.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing for the register file scoreboard: index width, data width, register count.
package regfile_scoreboard_pkg;

    localparam int unsigned W_RD  = 5;
    localparam int unsigned W_OPR = 32;
    localparam int unsigned N_REG = 2 ** W_RD;
    localparam int unsigned WORD  = W_OPR;

    typedef logic [W_RD-1:0]  reg_idx_t;
    typedef logic [W_OPR-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, reserve, writeback and cancel signals between the issue stage and the scoreboard.
interface regfile_scoreboard_if #(
    parameter int unsigned W_RD  = regfile_scoreboard_pkg::W_RD,
    parameter int unsigned W_OPR = regfile_scoreboard_pkg::W_OPR
);
    logic [W_RD-1:0]  r0_i;
    logic [W_RD-1:0]  r1_i;
    logic             w_reserve_i;
    logic [W_OPR-1:0] r_opr0_o;
    logic [W_OPR-1:0] r_opr1_o;
    logic             reserved_o;
    logic             wb_v_i;
    logic [W_RD-1:0]  wb_r_i;
    logic [W_OPR-1:0] wb_data_i;
    logic             cancel_v_i;
    logic [W_RD-1:0]  cancel_r_i;
    logic             busy_o;

    modport master (
        output r0_i, r1_i, w_reserve_i, wb_v_i, wb_r_i, wb_data_i, cancel_v_i, cancel_r_i,
        input  r_opr0_o, r_opr1_o, reserved_o, busy_o
    );

    modport slave (
        input  r0_i, r1_i, w_reserve_i, wb_v_i, wb_r_i, wb_data_i, cancel_v_i, cancel_r_i,
        output r_opr0_o, r_opr1_o, reserved_o, busy_o
    );
endinterface

// File: rtl/regfile_scoreboard_reg_reserve_table.sv
// Per-register pending-write bits; a reservation in the same cycle wins over writeback/cancel clears.
module reg_reserve_table #(
    parameter int unsigned W_RD  = regfile_scoreboard_pkg::W_RD,
    parameter int unsigned N_REG = regfile_scoreboard_pkg::N_REG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_v,
    input  logic [W_RD-1:0] set_r,
    input  logic            wb_v,
    input  logic [W_RD-1:0] wb_r,
    input  logic            cancel_v,
    input  logic [W_RD-1:0] cancel_r,
    input  logic [W_RD-1:0] rd0_r,
    input  logic [W_RD-1:0] rd1_r,
    output logic            rd0_res,
    output logic            rd1_res,
    output logic            busy
);
    import regfile_scoreboard_pkg::*;

    logic [N_REG-1:0] res;
    logic [N_REG-1:0] set_mask;
    logic [N_REG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_v)    set_mask[set_r]    = 1'b1;
        if (wb_v)     clr_mask[wb_r]     = 1'b1;
        if (cancel_v) clr_mask[cancel_r] = 1'b1;
    end

    // Clear first, then OR in the set so a same-cycle reserve leaves the bit high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res <= '0;
        end else begin
            res <= (res & ~clr_mask) | set_mask;
        end
    end

    assign rd0_res = res[rd0_r];
    assign rd1_res = res[rd1_r];
    assign busy    = |res;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle writeback bypass and a RAW-hazard scoreboard on the read ports.
module regfile_scoreboard #(
    parameter int unsigned W_RD  = regfile_scoreboard_pkg::W_RD,
    parameter int unsigned W_OPR = regfile_scoreboard_pkg::W_OPR,
    parameter int unsigned N_REG = regfile_scoreboard_pkg::N_REG
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    import regfile_scoreboard_pkg::*;

    logic [W_OPR-1:0] regs [N_REG];
    logic             wb_hit0;
    logic             wb_hit1;
    logic             res0;
    logic             res1;
    logic             busy;

    assign wb_hit0 = bus.wb_v_i && (bus.wb_r_i == bus.r0_i);
    assign wb_hit1 = bus.wb_v_i && (bus.wb_r_i == bus.r1_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_v_i) begin
            regs[bus.wb_r_i] <= bus.wb_data_i;
        end
    end

    reg_reserve_table #(
        .W_RD  (W_RD),
        .N_REG (N_REG)
    ) u_reserve (
        .clk      (clk),
        .reset    (reset),
        .set_v    (bus.w_reserve_i),
        .set_r    (bus.r0_i),
        .wb_v     (bus.wb_v_i),
        .wb_r     (bus.wb_r_i),
        .cancel_v (bus.cancel_v_i),
        .cancel_r (bus.cancel_r_i),
        .rd0_r    (bus.r0_i),
        .rd1_r    (bus.r1_i),
        .rd0_res  (res0),
        .rd1_res  (res1),
        .busy     (busy)
    );

    // A writeback landing this cycle both supplies the operand and resolves its hazard.
    always_comb begin
        bus.r_opr0_o   = wb_hit0 ? bus.wb_data_i : regs[bus.r0_i];
        bus.r_opr1_o   = wb_hit1 ? bus.wb_data_i : regs[bus.r1_i];
        bus.reserved_o = (res0 && !wb_hit0) || (res1 && !wb_hit1);
        bus.busy_o     = busy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised bench for regfile_scoreboard with a behavioural register/reservation model and directed cases.
module tb_regfile_scoreboard;

    localparam int W_RD  = 5;
    localparam int W_OPR = 32;
    localparam int N_REG = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   run   = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W_OPR-1:0] m_reg [N_REG];
    bit               m_res [N_REG];

    regfile_scoreboard_if #(.W_RD(W_RD), .W_OPR(W_OPR)) bus ();

    regfile_scoreboard #(
        .W_RD  (W_RD),
        .W_OPR (W_OPR),
        .N_REG (N_REG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W_OPR-1:0] act, input logic [W_OPR-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rv, input int r0, input int r1,
                         input bit wv, input int wr, input logic [W_OPR-1:0] wd,
                         input bit cv, input int cr);
        bus.w_reserve_i = rv;
        bus.r0_i        = W_RD'(r0);
        bus.r1_i        = W_RD'(r1);
        bus.wb_v_i      = wv;
        bus.wb_r_i      = W_RD'(wr);
        bus.wb_data_i   = wd;
        bus.cancel_v_i  = cv;
        bus.cancel_r_i  = W_RD'(cr);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_idx();
        if ($urandom_range(0, 3) != 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, N_REG - 1));
    endfunction

    // Model: registers and pending bits updated from the rules at each edge, wiped by reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REG; i++) begin
                m_reg[i] = '0;
                m_res[i] = 1'b0;
            end
        end else begin
            if (bus.wb_v_i) begin
                m_reg[bus.wb_r_i] = bus.wb_data_i;
                m_res[bus.wb_r_i] = 1'b0;
            end
            if (bus.cancel_v_i) m_res[bus.cancel_r_i] = 1'b0;
            if (bus.w_reserve_i) m_res[bus.r0_i] = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [W_OPR-1:0] e0, e1;
        bit h0, h1, er, eb;
        if (run) begin
            h0 = bus.wb_v_i && (bus.wb_r_i == bus.r0_i);
            h1 = bus.wb_v_i && (bus.wb_r_i == bus.r1_i);
            e0 = h0 ? bus.wb_data_i : m_reg[bus.r0_i];
            e1 = h1 ? bus.wb_data_i : m_reg[bus.r1_i];
            er = (m_res[bus.r0_i] && !h0) || (m_res[bus.r1_i] && !h1);
            eb = 1'b0;
            for (int i = 0; i < N_REG; i++) if (m_res[i]) eb = 1'b1;
            chk("model_opr0", bus.r_opr0_o, e0);
            chk("model_opr1", bus.r_opr1_o, e1);
            chk("model_reserved", W_OPR'(bus.reserved_o), W_OPR'(er));
            chk("model_busy", W_OPR'(bus.busy_o), W_OPR'(eb));
        end
    end

    initial begin
        for (int i = 0; i < N_REG; i++) begin
            m_reg[i] = '0;
            m_res[i] = 1'b0;
        end
        drive(0, 3, 7, 0, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        run = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_opr0", bus.r_opr0_o, 32'h0);
        chk("rst_opr1", bus.r_opr1_o, 32'h0);
        chk("rst_reserved", W_OPR'(bus.reserved_o), 32'h0);
        chk("rst_busy", W_OPR'(bus.busy_o), 32'h0);

        // Reserve r5, visible the following cycle
        next_cycle(); drive(1, 5, 0, 0, 0, '0, 0, 0);
        @(negedge clk);
        chk("rsv_same_cycle", W_OPR'(bus.reserved_o), 32'h0);
        next_cycle(); drive(0, 0, 5, 0, 0, '0, 0, 0);
        @(negedge clk);
        chk("rsv5_reserved", W_OPR'(bus.reserved_o), 32'h1);
        chk("rsv5_busy", W_OPR'(bus.busy_o), 32'h1);

        // Writeback to r5 bypasses and masks the hazard
        next_cycle(); drive(0, 0, 5, 1, 5, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        chk("wb5_bypass", bus.r_opr1_o, 32'hDEADBEEF);
        chk("wb5_reserved", W_OPR'(bus.reserved_o), 32'h0);
        next_cycle(); drive(0, 0, 5, 0, 0, '0, 0, 0);
        @(negedge clk);
        chk("wb5_after_busy", W_OPR'(bus.busy_o), 32'h0);
        chk("wb5_after_data", bus.r_opr1_o, 32'hDEADBEEF);

        // Cancel r4: bit drops, data retained, cancel does not mask the hazard
        next_cycle(); drive(0, 0, 0, 1, 4, 32'hA5, 0, 0);
        next_cycle(); drive(1, 4, 0, 0, 0, '0, 0, 0);
        next_cycle(); drive(0, 4, 0, 0, 0, '0, 1, 4);
        @(negedge clk);
        chk("cancel_no_mask", W_OPR'(bus.reserved_o), 32'h1);
        next_cycle(); drive(0, 4, 0, 0, 0, '0, 0, 0);
        @(negedge clk);
        chk("cancel4_reserved", W_OPR'(bus.reserved_o), 32'h0);
        chk("cancel4_busy", W_OPR'(bus.busy_o), 32'h0);
        chk("cancel4_data", bus.r_opr0_o, 32'hA5);

        // Reserve and writeback r9 together: set wins, data still written
        next_cycle(); drive(1, 9, 0, 1, 9, 32'h12, 0, 0);
        next_cycle(); drive(0, 9, 9, 0, 0, '0, 0, 0);
        @(negedge clk);
        chk("r9_data", bus.r_opr0_o, 32'h12);
        chk("r9_reserved", W_OPR'(bus.reserved_o), 32'h1);
        next_cycle(); drive(0, 0, 0, 0, 0, '0, 1, 9);
        next_cycle(); drive(0, 0, 0, 0, 0, '0, 0, 0);
        @(negedge clk);
        chk("r9_cleared_busy", W_OPR'(bus.busy_o), 32'h0);

        // Asynchronous reset mid-cycle with r2 and r6 pending
        next_cycle(); drive(1, 2, 0, 0, 0, '0, 0, 0);
        next_cycle(); drive(1, 6, 0, 0, 0, '0, 0, 0);
        next_cycle(); drive(0, 2, 6, 0, 0, '0, 0, 0);
        #1;
        chk("pre_rst_busy", W_OPR'(bus.busy_o), 32'h1);
        drive(0, 2, 6, 1, 2, 32'h77, 1, 6);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", W_OPR'(bus.busy_o), 32'h0);
        chk("async_rst_reserved", W_OPR'(bus.reserved_o), 32'h0);
        next_cycle(); reset = 1'b0; drive(0, 2, 6, 0, 0, '0, 0, 0);
        @(negedge clk);
        chk("rst_ignores_wb", bus.r_opr0_o, 32'h0);
        chk("rst_after_busy", W_OPR'(bus.busy_o), 32'h0);

        // Randomised traffic with occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            reset = 1'b0;
            drive($urandom_range(0, 2) == 0, rand_idx(), rand_idx(),
                  $urandom_range(0, 2) == 0, rand_idx(), $urandom(),
                  $urandom_range(0, 4) == 0, rand_idx());
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
            end
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        run = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
